uart_stream_generate: RTL

UART_STREAM_GENERATE -- requirements
Module: uart_stream_generate

---
 rtl/uart_stream_generate.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_stream_generate.sv
`timescale 1ns/1ps
// UART line generator: serialises an NBYTES word (auto-started from INIT_DATA or on start).
// Define UART_GEN_PARITY_EN to append an even-parity bit to every frame.
`ifndef DEFAULT_BAUD
`define DEFAULT_BAUD 16
`endif

module uart_stream_generate #(
    parameter int                  BAUD        = `DEFAULT_BAUD,
    parameter int                  NBYTES      = 4,
    parameter logic [8*NBYTES-1:0] INIT_DATA   = 32'ha14e28c5,
    parameter int                  AUTO_START  = 1,
    parameter int                  START_DELAY = 100,
    parameter int                  GAP         = 0,
    parameter int                  MSB_FIRST   = 1,
    parameter int                  REPEAT      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] data,
    output logic                rx,
    output logic                busy,
    output logic                done,
    output logic [3:0]          byte_idx
);
    localparam int W       = 8*NBYTES;
    localparam int CNT_MAX = (BAUD > START_DELAY) ? ((BAUD > GAP) ? BAUD : GAP)
                                                  : ((START_DELAY > GAP) ? START_DELAY : GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_START,
        S_DATA,
`ifdef UART_GEN_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       byte_q, byte_d;
    logic [W-1:0]     word_q, word_d;
    logic [7:0]       sh_q, sh_d;
    logic             rx_q, rx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UART_GEN_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             baud_end;
    logic             launch;
    logic [3:0]       launch_idx;
    logic [W-1:0]     launch_word;
    logic [7:0]       launch_byte;

    // Byte idx counts in transmit order; map it onto the word's bit position.
    function automatic logic [7:0] pick_byte(input logic [W-1:0] word, input logic [3:0] idx);
        int           sel;
        logic [W-1:0] shifted;
        sel     = (MSB_FIRST != 0) ? (NBYTES - 1 - int'(idx)) : int'(idx);
        shifted = word >> (8*sel);
        return shifted[7:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        word_d      = word_q;
        sh_d        = sh_q;
        rx_d        = rx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef UART_GEN_PARITY_EN
        par_d       = par_q;
`endif
        baud_end    = (cnt_q == CNT_W'(BAUD - 1));
        launch      = 1'b0;
        launch_idx  = byte_q;
        launch_word = word_q;

        case (state_q)
            S_IDLE, S_DELAY: begin
                if (start) begin
                    word_d      = data;
                    launch_word = data;
                    launch      = 1'b1;
                    launch_idx  = '0;
                end else if (state_q == S_DELAY) begin
                    if (cnt_q == CNT_W'(START_DELAY)) begin
                        word_d      = INIT_DATA;
                        launch_word = INIT_DATA;
                        launch      = 1'b1;
                        launch_idx  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    rx_d    = sh_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    cnt_d = '0;
                    sh_d  = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
`ifdef UART_GEN_PARITY_EN
                        state_d = S_PARITY;
                        rx_d    = par_q;
`else
                        state_d = S_STOP;
                        rx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        rx_d  = sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_GEN_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    rx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    cnt_d = '0;
                    if (byte_q == 4'(NBYTES - 1)) begin
                        done_d = 1'b1;
                        byte_d = '0;
                        if (REPEAT != 0) begin
                            if (GAP > 0) begin
                                state_d = S_GAP;
                            end else begin
                                launch     = 1'b1;
                                launch_idx = '0;
                            end
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        byte_d = byte_q + 4'd1;
                        if (GAP > 0) begin
                            state_d = S_GAP;
                        end else begin
                            launch     = 1'b1;
                            launch_idx = byte_q + 4'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                // byte_q already points at the byte that follows the gap.
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    launch     = 1'b1;
                    launch_idx = byte_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        launch_byte = pick_byte(launch_word, launch_idx);
        if (launch) begin
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
            byte_d  = launch_idx;
            sh_d    = launch_byte;
            rx_d    = 1'b0;
            busy_d  = 1'b1;
`ifdef UART_GEN_PARITY_EN
            par_d   = ^launch_byte;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= (AUTO_START != 0) ? S_DELAY : S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= INIT_DATA;
            sh_q    <= '0;
            rx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_GEN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_GEN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign rx       = rx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign byte_idx = byte_q;

endmodule
